// File: rtl/breakout_game_ctrl.sv
// Breakout game controller: game FSM, N-digit BCD score, high score, lives and
// new-ball / game-over timers driven by hit/miss/start edges and a tick strobe.
module breakout_game_ctrl #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_STEP    = 1,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned NEWBALL_TICKS = 60,
  parameter int unsigned OVER_TICKS    = 180
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  hit,
  input  logic                  miss,
  output logic [1:0]            state,
  output logic                  gra_still,
  output logic                  ball_reset,
  output logic [3:0]            lives,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   hi_q, hi_d;
  logic [3:0]      lives_q, lives_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ball_reset_q, ball_reset_d;
  logic            start_q, hit_q, miss_q;
  logic            start_rise, hit_rise, miss_rise;

  // BCD add of SCORE_STEP with full ripple carry; overflow saturates or wraps
  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] a);
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic [4:0]    c;
    r = '0;
    c = 5'(SCORE_STEP);
    for (int i = 0; i < int'(DIGITS); i++) begin
      s = 5'(a[4*i +: 4]) + c;
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 5'd1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 5'd0;
      end
    end
    if ((c != 5'd0) && (WRAP == 0)) r = {DIGITS{4'h9}};
    return r;
  endfunction

  assign start_rise = start & ~start_q;
  assign hit_rise   = hit   & ~hit_q;
  assign miss_rise  = miss  & ~miss_q;

  // State, datapath and edge-detect registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_NEWGAME;
      score_q      <= '0;
      hi_q         <= '0;
      lives_q      <= 4'(LIVES);
      timer_q      <= '0;
      ball_reset_q <= 1'b0;
      start_q      <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      hi_q         <= hi_d;
      lives_q      <= lives_d;
      timer_q      <= timer_d;
      ball_reset_q <= ball_reset_d;
      start_q      <= start;
      hit_q        <= hit;
      miss_q       <= miss;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    hi_d         = hi_q;
    lives_d      = lives_q;
    timer_d      = timer_q;
    ball_reset_d = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        if (start_rise) begin
          state_d      = ST_PLAY;
          score_d      = '0;
          lives_d      = 4'(LIVES);
          ball_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_rise) score_d = bcd_add(score_q);
        if (miss_rise) begin
          if (lives_q > 4'd1) begin
            lives_d = lives_q - 4'd1;
            timer_d = TW'(NEWBALL_TICKS);
            state_d = ST_NEWBALL;
          end else begin
            lives_d = 4'd0;
            timer_d = TW'(OVER_TICKS);
            state_d = ST_OVER;
            // score_d already includes a same-cycle hit
            if (score_d > hi_q) hi_d = score_d;
          end
        end
      end
      ST_NEWBALL: begin
        if (tick) begin
          if (timer_q == TW'(1)) begin
            timer_d      = '0;
            state_d      = ST_PLAY;
            ball_reset_d = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          timer_d = '0;
          state_d = ST_NEWGAME;
        end else if (tick) begin
          if (timer_q == TW'(1)) begin
            timer_d = '0;
            state_d = ST_NEWGAME;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  assign state      = state_q;
  assign gra_still  = (state_q != ST_PLAY);
  assign ball_reset = ball_reset_q;
  assign lives      = lives_q;
  assign score_bcd  = score_q;
  assign hi_bcd     = hi_q;

endmodule
